// File: rtl/m_shiftreg_pkg.sv
// Shared definitions for the SIPO/PISO serial link: FSM encodings and default word width.
package m_shiftreg_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  localparam int SR_WIDTH = 4;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } shift_state_e;

endpackage

// File: rtl/m_loadcounter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module m_loadcounter #(
  parameter int W = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         LOAD,
  input  logic         DEC,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q,
  output logic         ZERO
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (LOAD) begin
      cnt_d = D;
    end else if (DEC && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Q    = cnt_q;
  assign ZERO = (cnt_q == '0);

endmodule

// File: rtl/m_pisoregister.sv
// Parallel-in serial-out transmitter: takes a word on a valid/ready load port and
// shifts it out one bit per clock, with back-to-back words and no idle gap.
module m_pisoregister
  import m_shiftreg_pkg::*;
#(
  parameter int WIDTH     = SR_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] PI,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  output logic             SO,
  output logic             SO_VALID,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  shift_state_e     state_d, state_q;
  logic [WIDTH-1:0] shreg_d, shreg_q;
  logic [WIDTH-1:0] shreg_next;
  logic [CW-1:0]    cnt_val;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic             in_shift;
  logic             last_bit;
  logic             accept;

  assign in_shift = (state_q == S_SHIFT);
  assign last_bit = in_shift && cnt_zero;

  // Ready only from registered state, so nothing combinational reaches the outputs.
  assign LOAD_READY = !in_shift || cnt_zero;
  assign accept     = LOAD_VALID && LOAD_READY && !CLR;

  always_comb begin
    shreg_next = '0;
    if (MSB_FIRST) begin
      shreg_next = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shreg_next = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_load = accept;
    cnt_dec  = in_shift && (cnt_val != '0);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shreg_d = PI;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d = shreg_next;
        if (cnt_zero) begin
          if (accept) begin
            shreg_d = PI;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  m_loadcounter #(
    .W(CW)
  ) u_cnt (
    .CLK (CLK),
    .RST (CLR),
    .LOAD(cnt_load),
    .DEC (cnt_dec),
    .D   (CNT_LAST),
    .Q   (cnt_val),
    .ZERO(cnt_zero)
  );

  assign SO       = in_shift && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign SO_VALID = in_shift;
  assign DONE     = last_bit;

endmodule
